jtcps1_sndcmd: RTL and testbench
================================

# jtcps1_sndcmd

Main-CPU-side writer of the CPS1 sound command latches. It turns 68000 byte writes into the two 8-bit latch values read by the Z80 sound subsystem: command (`snd_latch0`) and fade/aux (`snd_latch1`). Latch0 commands pass through a small FIFO, so back-to-back 68000 writes are not lost while the slow Z80 (3.58 MHz cen) polls. The block sits between the main-CPU address decoder and the sound module's `snd_latch0`/`snd_latch1` inputs.

## Interface
Parameters:
- `DEPTH`, default 4: latch0 FIFO entries, power of two, 2..16.
- `HOLD`, default 16'd4800: minimum clk cycles a latch0 value stays presented after load (100 µs at 48 MHz).

Ports:
- `clk` in, 1: 48 MHz system clock.
- `rst` in, 1: **synchronous, active-high reset**.
- `main_cs0` in, 1: decoder select for the latch0 register.
- `main_cs1` in, 1: decoder select for the latch1 register.
- `main_rnw` in, 1: 68000 read/not-write.
- `main_dsn` in, 2: 68000 data strobes, active low; `[0]` = LSB lane.
- `main_dout` in, 16: 68000 write data; only `[7:0]` used.
- `latch0_rd` in, 1: one-clk pulse from the sound side when the Z80 completes a read of latch0.
- `snd_latch0` out, 8: presented command byte.
- `snd_latch1` out, 8: presented aux byte.
- `fifo_cnt` out, `$clog2(DEPTH)+1`: pending FIFO entries.
- `fifo_full` out, 1: `fifo_cnt == DEPTH`.
- `overrun` out, 1: sticky, set when a push is dropped.

## Operation
- Write strobe: `wrN = main_csN & ~main_rnw & ~main_dsn[0]`, registered as `wrN_l`.
- Write event: rising edge, i.e. `wrN & ~wrN_l`. A strobe held for many clocks produces exactly one event. Writes with only `dsn[1]` low are ignored.
- Latch1: a write event loads `main_dout[7:0]` into `snd_latch1` on the same clk edge. No buffering; the last write wins.
- Latch0 write event pushes `main_dout[7:0]` into the FIFO.
  - Full and no pop this cycle: data is dropped and `overrun` is set.
  - Full with a simultaneous pop: the push is accepted.
- Presenter state: `cur0` (drives `snd_latch0`), `consumed` flag, `hold_cnt` down-counter.
- Advance condition: `consumed & (hold_cnt == 0) & (fifo_cnt != 0)`. When it holds:
  - `cur0` ← FIFO head (pop);
  - `consumed` ← 0;
  - `hold_cnt` ← `HOLD`.
- `hold_cnt` decrements every clk while nonzero. It saturates at 0.
- `latch0_rd` sets `consumed` only when no advance occurs in the same cycle. A read coinciding with a load refers to the old value and is discarded.
- FIFO empty: `cur0` keeps the last value indefinitely, matching the real latch.
- Reset values:
  - `snd_latch0 = snd_latch1 = 8'hFF`;
  - `consumed = 1`, `hold_cnt = 0`;
  - FIFO empty, `fifo_cnt = 0`, `fifo_full = 0`, `overrun = 0`;
  - `wrN_l = 0`.
- Reset mid-operation discards pending entries.
- Pointers wrap modulo `DEPTH`. `fifo_cnt` counts to `DEPTH` inclusive.

## Timing
- Latch1: a write event at edge N gives the new `snd_latch1` after edge N.
- Latch0 with the FIFO empty and the presenter idle:
  - push at edge N;
  - advance at edge N+1;
  - `snd_latch0` valid after N+1, i.e. 2 clks from the first sampled strobe.
- Consecutive commands are spaced by at least `max(HOLD, time to latch0_rd)` clks.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `fifo_cnt` and `fifo_full` reflect the push/pop of the previous edge.

## Structure
- Shared header `jtcps1_snd.vh`:
  - latch reset value `8'hFF`;
  - default `HOLD` constant;
  - the LSB-lane index.
- One sub-module, `jtcps1_cmd_fifo`: synchronous FIFO of `DEPTH` × 8 with push/pop, head data, count and full. Same-cycle push+pop is allowed when full or empty+nonempty.
- Top level holds the edge detectors, latch1 register, presenter FSM and overrun flag.

## Test plan
- Reset, then idle: `snd_latch0 = snd_latch1 = FF`, `fifo_cnt = 0`, `overrun = 0`.
- Single latch0 write of `8'h23` with the strobe held 20 clks: exactly one push; `snd_latch0 = 23` 2 clks after the strobe; `fifo_cnt` returns to 0.
- Burst of writes `01,02,03,04` 10 clks apart, `latch0_rd` pulsed 100 clks after each load: values appear in order, each held ≥ `HOLD` clks; no overrun.
- Five writes with no `latch0_rd`: `fifo_full = 1` after the fourth pending entry; the fifth write is dropped and `overrun = 1`; `snd_latch0` stays at the first value.
- `latch0_rd` in the same clk as an advance: the new value is not marked consumed; the next command waits for another `latch0_rd`.
- Latch1 write `8'h40` with `dsn = 2'b01` (MSB only): ignored; with `dsn = 2'b10`: `snd_latch1 = 40` next clk.

Source files
------------

// File: rtl/jtcps1_sndcmd_pkg.sv
// Shared constants and types for the CPS1 sound command latch writer.
package jtcps1_sndcmd_pkg;

    // Value both latches show after reset, like the real open-bus latch
    localparam logic [7:0]  LatchRst    = 8'hFF;
    // 100 us at 48 MHz
    localparam logic [15:0] HoldDefault = 16'd4800;
    // 68000 data strobe lane carrying D[7:0]
    localparam logic [0:0]  LsbLane     = 1'b0;

    // Presenter: current latch0 value still waiting for the Z80, or already read
    typedef enum logic {
        StPending,
        StConsumed
    } pres_state_t;

endpackage

// File: rtl/jtcps1_cmd_fifo.sv
// Small synchronous byte FIFO buffering latch0 commands.
module jtcps1_cmd_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               head,
    output logic [$clog2(DEPTH):0]   cnt,
    output logic                     full
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          full_q;
    logic          push_ok;
    logic          pop_ok;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then
    assign pop_ok  = pop & (cnt_q != '0);
    assign push_ok = push & (~full_q | pop_ok);

    // Next occupancy from the accepted push/pop pair
    always_comb begin
        cnt_d = cnt_q;
        unique case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
            full_q <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == FullCnt);
        end
    end

    // Storage needs no reset: entries are only read once written
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

    assign head = mem[rd_ptr];
    assign cnt  = cnt_q;
    assign full = full_q;

endmodule

// File: rtl/jtcps1_sndcmd.sv
// Main-CPU side writer of the CPS1 sound command latches (command + aux).
module jtcps1_sndcmd
    import jtcps1_sndcmd_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter logic [15:0] HOLD  = HoldDefault
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     main_cs0,
    input  logic                     main_cs1,
    input  logic                     main_rnw,
    input  logic [1:0]               main_dsn,
    input  logic [15:0]              main_dout,
    input  logic                     latch0_rd,
    output logic [7:0]               snd_latch0,
    output logic [7:0]               snd_latch1,
    output logic [$clog2(DEPTH):0]   fifo_cnt,
    output logic                     fifo_full,
    output logic                     overrun
);
    logic        wr0;
    logic        wr1;
    logic        wr0_l;
    logic        wr1_l;
    logic        ev0;
    logic        ev1;
    logic        adv;
    logic [7:0]  fifo_head;
    logic [7:0]  cur0;
    logic [7:0]  lat1;
    logic [15:0] hold_cnt;
    logic        ovr_q;
    pres_state_t state_q;

    // Only the low byte lane reaches the Z80 latches
    logic unused_bits;
    assign unused_bits = ^{main_dout[15:8], main_dsn[~LsbLane]};

    assign wr0 = main_cs0 & ~main_rnw & ~main_dsn[LsbLane];
    assign wr1 = main_cs1 & ~main_rnw & ~main_dsn[LsbLane];
    assign ev0 = wr0 & ~wr0_l;
    assign ev1 = wr1 & ~wr1_l;

    // Next command is presented once the Z80 has read the current one and it was held long enough
    assign adv = (state_q == StConsumed) & (hold_cnt == 16'd0) & (fifo_cnt != '0);

    jtcps1_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (ev0),
        .pop   (adv),
        .din   (main_dout[7:0]),
        .head  (fifo_head),
        .cnt   (fifo_cnt),
        .full  (fifo_full)
    );

    // Strobe edge detectors and the unbuffered aux latch
    always_ff @(posedge clk) begin
        if (rst) begin
            wr0_l <= 1'b0;
            wr1_l <= 1'b0;
            lat1  <= LatchRst;
        end else begin
            wr0_l <= wr0;
            wr1_l <= wr1;
            if (ev1) lat1 <= main_dout[7:0];
        end
    end

    // Presenter: load from FIFO, hold for HOLD clks, wait for the Z80 read
    always_ff @(posedge clk) begin
        if (rst) begin
            cur0     <= LatchRst;
            state_q  <= StConsumed;
            hold_cnt <= 16'd0;
        end else if (adv) begin
            cur0     <= fifo_head;
            state_q  <= StPending;
            hold_cnt <= HOLD;
        end else begin
            if (hold_cnt != 16'd0) hold_cnt <= hold_cnt - 16'd1;
            // A read coinciding with a load referred to the old value, hence only here
            if (latch0_rd) state_q <= StConsumed;
        end
    end

    // Sticky flag for a command dropped on a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_q <= 1'b0;
        end else if (ev0 & fifo_full & ~adv) begin
            ovr_q <= 1'b1;
        end
    end

    assign snd_latch0 = cur0;
    assign snd_latch1 = lat1;
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_jtcps1_sndcmd.sv
// Directed self-checking bench for jtcps1_sndcmd.
module tb_jtcps1_sndcmd;
    localparam int unsigned DEPTH = 4;
    localparam logic [15:0] HOLD  = 16'd50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        main_cs0 = 1'b0;
    logic        main_cs1 = 1'b0;
    logic        main_rnw = 1'b1;
    logic [1:0]  main_dsn = 2'b11;
    logic [15:0] main_dout = 16'h0000;
    logic        latch0_rd = 1'b0;
    logic [7:0]  snd_latch0;
    logic [7:0]  snd_latch1;
    logic [2:0]  fifo_cnt;
    logic        fifo_full;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    jtcps1_sndcmd #(
        .DEPTH (DEPTH),
        .HOLD  (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .main_cs0   (main_cs0),
        .main_cs1   (main_cs1),
        .main_rnw   (main_rnw),
        .main_dsn   (main_dsn),
        .main_dout  (main_dout),
        .latch0_rd  (latch0_rd),
        .snd_latch0 (snd_latch0),
        .snd_latch1 (snd_latch1),
        .fifo_cnt   (fifo_cnt),
        .fifo_full  (fifo_full),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance n clocks; returns 1 time unit after the last rising edge
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr0(input logic [7:0] d, input int gap);
        main_cs0  = 1'b1;
        main_rnw  = 1'b0;
        main_dsn  = 2'b10;
        main_dout = {8'h00, d};
        tick(2);
        main_cs0  = 1'b0;
        main_rnw  = 1'b1;
        main_dsn  = 2'b11;
        tick(gap);
    endtask

    task automatic pulse_rd();
        latch0_rd = 1'b1;
        tick(1);
        latch0_rd = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        // Reset and idle
        tick(3);
        rst = 1'b0;
        tick(2);
        check("rst_latch0", snd_latch0, 8'hFF);
        check("rst_latch1", snd_latch1, 8'hFF);
        check("rst_cnt", fifo_cnt, 0);
        check("rst_full", fifo_full, 0);
        check("rst_overrun", overrun, 0);

        // Single write, strobe held 20 clks
        main_cs0  = 1'b1;
        main_rnw  = 1'b0;
        main_dsn  = 2'b10;
        main_dout = 16'hAB23;
        tick(1);
        check("single_push_cnt", fifo_cnt, 1);
        check("single_not_yet", snd_latch0, 8'hFF);
        tick(1);
        check("single_latch0", snd_latch0, 8'h23);
        check("single_cnt0", fifo_cnt, 0);
        tick(18);
        check("single_held_cnt", fifo_cnt, 0);
        check("single_held_val", snd_latch0, 8'h23);
        main_cs0 = 1'b0;
        main_rnw = 1'b1;
        main_dsn = 2'b11;
        pulse_rd();
        tick(60);

        // Burst 01..04, 10 clks apart; read 100 clks after each load
        fork
            begin
                for (int i = 0; i < 4; i++) wr0(8'(i + 1), 8);
            end
            begin
                int last_load;
                last_load = 0;
                for (int k = 0; k < 4; k++) begin
                    logic [7:0] exp_v;
                    exp_v = 8'(k + 1);
                    for (int t = 0; t < 300 && snd_latch0 != exp_v; t++) tick(1);
                    check("burst_val", snd_latch0, exp_v);
                    if (k > 0) check("burst_gap", cyc - last_load, 102);
                    last_load = cyc;
                    tick(100);
                    check("burst_hold", snd_latch0, exp_v);
                    if (k < 3) pulse_rd();
                end
            end
        join
        check("burst_overrun", overrun, 0);
        check("burst_cnt", fifo_cnt, 0);

        // 04 is still unread: four writes fill the FIFO, the fifth is dropped
        for (int i = 0; i < 4; i++) wr0(8'hB1 + 8'(i), 3);
        check("fill_cnt", fifo_cnt, 4);
        check("fill_full", fifo_full, 1);
        check("fill_no_overrun", overrun, 0);
        wr0(8'hB5, 3);
        check("drop_overrun", overrun, 1);
        check("drop_cnt", fifo_cnt, 4);
        check("drop_latch0", snd_latch0, 8'h04);

        // Read releases B1 (hold long expired)
        pulse_rd();
        tick(1);
        check("drain_b1", snd_latch0, 8'hB1);
        check("drain_cnt3", fifo_cnt, 3);

        // Read early, then a second read exactly on the advance edge
        pulse_rd();
        tick(49);
        latch0_rd = 1'b1;
        tick(1);
        latch0_rd = 1'b0;
        check("coinc_b2", snd_latch0, 8'hB2);
        check("coinc_cnt2", fifo_cnt, 2);
        tick(60);
        check("coinc_wait_b2", snd_latch0, 8'hB2);
        check("coinc_wait_cnt", fifo_cnt, 2);
        pulse_rd();
        tick(1);
        check("coinc_b3", snd_latch0, 8'hB3);

        // Latch1: MSB-only write ignored, LSB write loads next clk
        main_cs1  = 1'b1;
        main_rnw  = 1'b0;
        main_dsn  = 2'b01;
        main_dout = 16'h0040;
        tick(1);
        check("l1_msb_ignored", snd_latch1, 8'hFF);
        main_cs1 = 1'b0;
        main_dsn = 2'b11;
        tick(1);
        main_cs1 = 1'b1;
        main_dsn = 2'b10;
        tick(1);
        check("l1_write", snd_latch1, 8'h40);
        check("l1_latch0_kept", snd_latch0, 8'hB3);
        main_cs1 = 1'b0;
        main_rnw = 1'b1;
        main_dsn = 2'b11;
        tick(2);

        // Reset mid-operation discards pending B4
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mrst_cnt", fifo_cnt, 0);
        check("mrst_latch0", snd_latch0, 8'hFF);
        check("mrst_latch1", snd_latch1, 8'hFF);
        check("mrst_overrun", overrun, 0);
        wr0(8'h55, 0);
        check("mrst_fresh", snd_latch0, 8'h55);
        check("mrst_fresh_cnt", fifo_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
